// File: rtl/irq_edge_arbiter.sv
// irq_edge_arbiter: synchronizes NUM_IRQ asynchronous interrupt lines,
// detects a per-line selectable edge, latches events as pending bits and
// presents one pending line at a time to the core using round-robin
// arbitration and a valid/ack handshake.
//
// Ports:
//   clk            clock
//   n_rst          asynchronous active-low reset
//   i_async_irq    raw asynchronous interrupt lines
//   i_irq_enable   per-line enable (quasi-static)
//   i_irq_posedge  per-line edge select, 1 = rising, 0 = falling
//   o_irq_valid    an interrupt is being presented
//   o_irq_id       index of the presented interrupt
//   i_irq_ack      core accepts the presented interrupt
//   o_irq_pending  pending bits (status readback)

// Multi-bit N-stage flop synchronizer; each bit is an independent line.
module irq_edge_arbiter_sync #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SYNC_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] r_stages [SYNC_DEPTH];

  // Shift chain: stage 0 samples the asynchronous input.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned s = 0; s < SYNC_DEPTH; s++) begin
        r_stages[s] <= '0;
      end
    end else begin
      r_stages[0] <= i_data;
      for (int unsigned s = 1; s < SYNC_DEPTH; s++) begin
        r_stages[s] <= r_stages[s-1];
      end
    end
  end

  assign o_data = r_stages[SYNC_DEPTH-1];

endmodule

module irq_edge_arbiter #(
  parameter  int unsigned NUM_IRQ       = 8,
  localparam int unsigned IRQ_IDX_WIDTH = $clog2(NUM_IRQ)
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [NUM_IRQ-1:0]       i_async_irq,
  input  logic [NUM_IRQ-1:0]       i_irq_enable,
  input  logic [NUM_IRQ-1:0]       i_irq_posedge,
  output logic                     o_irq_valid,
  output logic [IRQ_IDX_WIDTH-1:0] o_irq_id,
  input  logic                     i_irq_ack,
  output logic [NUM_IRQ-1:0]       o_irq_pending
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_valid;
  logic                     w_valid_nxt;
  logic [IRQ_IDX_WIDTH-1:0] r_id;
  logic [IRQ_IDX_WIDTH-1:0] w_id_nxt;
  logic [IRQ_IDX_WIDTH-1:0] r_rr_last;
  logic [IRQ_IDX_WIDTH-1:0] w_rr_nxt;

  logic [NUM_IRQ-1:0]       w_sync;
  logic [NUM_IRQ-1:0]       r_hist;
  logic [NUM_IRQ-1:0]       w_evt;
  logic [NUM_IRQ-1:0]       w_set;
  logic [NUM_IRQ-1:0]       w_clr;
  logic [NUM_IRQ-1:0]       r_pending;
  logic [NUM_IRQ-1:0]       w_cand;
  logic                     w_any;
  logic [IRQ_IDX_WIDTH-1:0] w_winner;
  logic                     w_ack_accept;

  irq_edge_arbiter_sync #(
    .DATA_WIDTH (NUM_IRQ),
    .SYNC_DEPTH (2)
  ) u_sync (
    .clk    (clk),
    .n_rst  (n_rst),
    .i_data (i_async_irq),
    .o_data (w_sync)
  );

  // History flop for edge detection; resetting to 0 means a line held high
  // through reset shows up as a rise, never as a fall.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_hist <= '0;
    end else begin
      r_hist <= w_sync;
    end
  end

  // Per-line edge select.
  assign w_evt = (i_irq_posedge & w_sync & ~r_hist) |
                 (~i_irq_posedge & ~w_sync & r_hist);

  assign w_ack_accept = (r_state == ST_PRESENT) && i_irq_ack;
  assign w_set        = w_evt & i_irq_enable;
  assign w_clr        = w_ack_accept ? (NUM_IRQ'(1) << r_id) : '0;

  // Pending bits; a set in the same cycle as the clear wins.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
    end
  end

  assign w_cand = r_pending & i_irq_enable;

  // Round-robin pick: first candidate ascending from rr_last+1 with wrap.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    for (int unsigned k = 0; k < NUM_IRQ; k++) begin
      int unsigned idx;
      idx = 32'(r_rr_last) + k + 32'd1;
      if (idx >= NUM_IRQ) begin
        idx = idx - NUM_IRQ;
      end
      if (!w_any && w_cand[IRQ_IDX_WIDTH'(idx)]) begin
        w_any    = 1'b1;
        w_winner = IRQ_IDX_WIDTH'(idx);
      end
    end
  end

  // FSM state and presentation registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= ST_IDLE;
      r_valid   <= 1'b0;
      r_id      <= '0;
      r_rr_last <= IRQ_IDX_WIDTH'(NUM_IRQ - 1);
    end else begin
      r_state   <= w_state_nxt;
      r_valid   <= w_valid_nxt;
      r_id      <= w_id_nxt;
      r_rr_last <= w_rr_nxt;
    end
  end

  // Next-state logic; the presented id is frozen until acked.
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_id_nxt    = r_id;
    w_rr_nxt    = r_rr_last;
    case (r_state)
      ST_IDLE: begin
        w_valid_nxt = 1'b0;
        if (w_any) begin
          w_id_nxt    = w_winner;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (i_irq_ack) begin
          w_rr_nxt    = r_id;
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_irq_valid   = r_valid;
  assign o_irq_id      = r_id;
  assign o_irq_pending = r_pending;

endmodule

// File: doc/irq_edge_arbiter.md
Name: irq_edge_arbiter

Overview:
- Collects NUM_IRQ asynchronous interrupt lines.
- Synchronizes each line and detects a runtime-selectable edge (posedge or negedge) per line.
- Latches detected events as pending bits.
- Presents one pending line at a time to the core through a valid/ack handshake, using round-robin arbitration.
- Sits between the external/peripheral interrupt pins and the core's exception/trap logic.

Parameters:
- NUM_IRQ, 8, number of interrupt lines (≥2).
- IRQ_IDX_WIDTH, $clog2(NUM_IRQ), width of the interrupt index. Derived; do not override.

Ports:
- clk  input  1  clock
- n_rst  input  1  reset, asynchronous, active-low
- i_async_irq  input  NUM_IRQ  raw asynchronous interrupt lines
- i_irq_enable  input  NUM_IRQ  per-line enable; synchronous, quasi-static
- i_irq_posedge  input  NUM_IRQ  per-line edge select; 1 = rising edge, 0 = falling edge
- o_irq_valid  output  1  an interrupt is being presented
- o_irq_id  output  IRQ_IDX_WIDTH  index of the presented interrupt
- i_irq_ack  input  1  core accepts the presented interrupt
- o_irq_pending  output  NUM_IRQ  current pending bits (status readback)

Behaviour:
- Reset (async, n_rst low):
  - All synchronizer flops, history flops and pending bits clear to 0.
  - o_irq_valid = 0, o_irq_id = 0, o_irq_pending = 0, FSM = IDLE, rr_last = NUM_IRQ-1.
  - Reset mid-presentation drops the presentation and all pending events.
- Synchronization: each line passes through a 2-flop synchronizer (synchronizer, DATA_WIDTH=NUM_IRQ, SYNC_DEPTH=2), then one history flop.
- Edge detection:
  - rise[i] = sync[i] & ~hist[i]; fall[i] = ~sync[i] & hist[i].
  - evt[i] = i_irq_posedge[i] ? rise[i] : fall[i]. Combinational, one cycle wide.
  - Because history resets to 0, a line held high through reset does not create a falling event.
- Pending:
  - pending[i] is set on the clock edge where evt[i] & i_irq_enable[i] is true.
  - It is cleared on the clock edge where i_irq_ack is accepted with o_irq_id == i.
  - Set wins over clear in the same cycle, so a new event is not lost.
  - Events on disabled lines are discarded. Bits already pending stay held while disabled but are masked from arbitration.
  - Repeated events on an already-pending line coalesce into one.
- Arbitration:
  - Candidates = pending & i_irq_enable.
  - Round-robin search starts at (rr_last+1) mod NUM_IRQ, ascending with wrap-around; the first candidate wins.
  - After reset, index 0 has highest priority.
- FSM (two states):
  - IDLE: o_irq_valid = 0. If any candidate exists, latch the winner into o_irq_id, set o_irq_valid = 1, go to PRESENT. Both are registered and visible the cycle after the decision.
  - PRESENT: o_irq_valid = 1 and o_irq_id holds stable until ack, even if the line is disabled meanwhile (no retraction). On i_irq_ack: clear pending[o_irq_id] (unless set-wins applies), rr_last <= o_irq_id, o_irq_valid <= 0, go to IDLE.
  - Back-to-back: at least one IDLE cycle between presentations, so maximum throughput is one interrupt per 2 cycles.
- i_irq_ack is ignored in IDLE.
- Latency: a level change first sampled at clk edge E1 produces the event during the cycle after E2. pending is set at E3. o_irq_valid = 1 after E4 (4 edges, FSM idle, no competing candidate).

Test Plan:
- Reset, all enabled, all posedge, raise line 3 → o_irq_pending[3] = 1 after edge 3; o_irq_valid = 1 with o_irq_id = 3 after edge 4; ack → pending = 0, valid = 0 next cycle.
- Raise lines 0, 2, 5 simultaneously, ack each immediately on valid → ids presented in order 0, 2, 5. Then raise 0 and 5 together → 5 is NOT presented first; order is 0, 5 (rr_last = 5 wraps to search from 6, then 7, then 0).
- Line 4 configured negedge and held high through reset: no event. Drop it low → id 4 presented. Raise it again → no event.
- Line 1 disabled, pulse it → pending[1] stays 0. Enable, pulse → pending set; disable while presented → id 1 held until ack.
- While id 6 is presented, a fresh edge on line 6 lands in the same cycle as the ack → pending[6] remains 1 and id 6 is re-presented after one IDLE cycle.
- Assert n_rst low while o_irq_valid = 1 with 3 lines pending → valid, id and pending all 0 immediately; after release, no spurious presentation.
